arbiter_puf_ctrl: RTL and testbench

Initiator-side controller that drives the arbiter PUF: walks a challenge sequence, issues the race pulse on each challenge, and samples the latched response through a synchronizer. Collects the response bits into one word and hands it out with a valid/ready handshake. Sits between system logic and the arbiter PUF's pulse/challenge/response pins.

---
 rtl/arbiter_puf_ctrl.sv | 178 +++++++++++++++++
 tb/tb_arbiter_puf_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/arbiter_puf_ctrl.sv
// Arbiter PUF initiator: walks challenges, pulses the PUF, collects responses.
// Optional majority voting per challenge: define ARBITER_PUF_VOTE_EN.
module arbiter_puf_ctrl #(
  parameter int CHAL_W     = 3,
  parameter int N_CHAL     = 8,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 4,
  parameter int VOTES      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CHAL_W-1:0] seed,
  output logic              busy,
  output logic              puf_pulse,
  output logic [CHAL_W-1:0] puf_challenge,
  input  logic              puf_response,
  output logic [N_CHAL-1:0] resp_word,
  output logic              resp_valid,
  input  logic              resp_ready
);

  localparam int HIGH_N = PULSE_CYC + SETTLE_CYC;
  localparam int CW = $clog2(HIGH_N);
  localparam int KW = (N_CHAL > 1) ? $clog2(N_CHAL) : 1;

  if ((VOTES % 2) == 0 || VOTES < 1) begin : g_bad_votes
    $error("VOTES must be odd and >= 1");
  end

  typedef enum logic [2:0] {
    IDLE, SETUP, HIGH, LOW, DONE
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        sync_q;
  logic              sync;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [KW-1:0]     k_q, k_d;
  logic [CHAL_W-1:0] seed_q, seed_d;
  logic [CHAL_W-1:0] chal_q;
  logic [N_CHAL-1:0] word_q, word_d;
  logic              pulse_q, valid_q, busy_q;
  logic              last_vote;

  assign sync = sync_q[1];

`ifdef ARBITER_PUF_VOTE_EN
  localparam int VW  = $clog2(VOTES + 1);
  localparam int VIW = (VOTES > 1) ? $clog2(VOTES) : 1;

  logic [VW-1:0]  vcnt_q, vcnt_d;
  logic [VIW-1:0] v_q, v_d;

  assign last_vote = (v_q == VIW'(VOTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vcnt_q <= '0;
      v_q    <= '0;
    end else begin
      vcnt_q <= vcnt_d;
      v_q    <= v_d;
    end
  end
`else
  assign last_vote = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    seed_d  = seed_q;
    word_d  = word_q;
`ifdef ARBITER_PUF_VOTE_EN
    vcnt_d  = vcnt_q;
    v_d     = v_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          seed_d  = seed;
          k_d     = '0;
          cnt_d   = '0;
          state_d = SETUP;
`ifdef ARBITER_PUF_VOTE_EN
          vcnt_d  = '0;
          v_d     = '0;
`endif
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = HIGH;
      end
      HIGH: begin
        if (cnt_q == CW'(HIGH_N - 1)) begin
          cnt_d   = '0;
          state_d = LOW;
`ifdef ARBITER_PUF_VOTE_EN
          vcnt_d = vcnt_q + VW'(sync);
          if (last_vote)
            word_d[k_q] = (vcnt_d > VW'(VOTES / 2));
`else
          word_d[k_q] = sync;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LOW: begin
        if (cnt_q == CW'(PULSE_CYC - 1)) begin
          cnt_d = '0;
          if (!last_vote) begin
`ifdef ARBITER_PUF_VOTE_EN
            v_d = v_q + VIW'(1);
`endif
            state_d = SETUP;
          end else if (k_q == KW'(N_CHAL - 1)) begin
            state_d = DONE;
          end else begin
            k_d     = k_q + KW'(1);
            state_d = SETUP;
          end
`ifdef ARBITER_PUF_VOTE_EN
          if (last_vote) begin
            v_d    = '0;
            vcnt_d = '0;
          end
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (resp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Challenge only moves on SETUP entry, when the pulse is already low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync_q  <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      seed_q  <= '0;
      chal_q  <= '0;
      word_q  <= '0;
      pulse_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], puf_response};
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      seed_q  <= seed_d;
      word_q  <= word_d;
      if (state_d == SETUP)
        chal_q <= seed_d + CHAL_W'(k_d);
      pulse_q <= (state_d == HIGH);
      valid_q <= (state_d == DONE);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign busy          = busy_q;
  assign puf_pulse     = pulse_q;
  assign puf_challenge = chal_q;
  assign resp_word     = word_q;
  assign resp_valid    = valid_q;

endmodule

// File: tb/tb_arbiter_puf_ctrl.sv
// Directed bench for arbiter_puf_ctrl with a small PUF response model.
// Set ARBITER_PUF_VOTE_EN to also exercise the voting build.
module tb_arbiter_puf_ctrl;

`ifdef ARBITER_PUF_VOTE_EN
  localparam int EV = 3;
`else
  localparam int EV = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] seed;
  logic       busy;
  logic       puf_pulse;
  logic [2:0] puf_challenge;
  logic       puf_response;
  logic [7:0] resp_word;
  logic       resp_valid;
  logic       resp_ready;

  int tests = 0;
  int fails = 0;

  arbiter_puf_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .seed(seed),
    .busy(busy),
    .puf_pulse(puf_pulse),
    .puf_challenge(puf_challenge),
    .puf_response(puf_response),
    .resp_word(resp_word),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, expv);
    end
  endtask

  function automatic logic model(input int mode,
                                 input int r,
                                 input logic [2:0] c);
    case (mode)
      0:       return 1'b1;
      1:       return c[0];
      2:       return (r % 3) != 2;
      default: return (r % 3) == 1;
    endcase
  endfunction

  task automatic run(input logic [2:0] sd,
                     input int mode,
                     input logic [7:0] ew,
                     input bit hold);
    int n, rises, viol, bbad, sbad;
    logic pp;
    logic [2:0] pc, ec;
    logic [2:0] seen [$];
    @(negedge clk);
    seed = sd;
    start = 1'b1;
    resp_ready = !hold;
    pp = puf_pulse;
    pc = puf_challenge;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0; rises = 0; viol = 0; bbad = 0;
    forever begin
      if (puf_pulse && !pp) begin
        seen.push_back(puf_challenge);
        rises++;
      end
      if (puf_challenge !== pc && (puf_pulse || pp))
        viol++;
      if (!puf_pulse)
        puf_response = model(mode, rises, puf_challenge);
      if (busy !== 1'b1) bbad++;
      pp = puf_pulse;
      pc = puf_challenge;
      if (resp_valid === 1'b1 || n >= 1000) break;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check($sformatf("latency s%0d", sd), n, 72 * EV);
    check($sformatf("word s%0d", sd), ew, resp_word);
    check($sformatf("evals s%0d", sd), rises, 8 * EV);
    foreach (seen[i]) begin
      ec = sd + 3'(i / EV);
      check($sformatf("chal s%0d #%0d", sd, i),
            seen[i], ec);
    end
    check($sformatf("chal_vs_pulse s%0d", sd), viol, 0);
    check($sformatf("busy_run s%0d", sd), bbad, 0);
    if (!hold) begin
      @(posedge clk);
      @(negedge clk);
      check("hs_valid", resp_valid, 0);
      check("hs_busy", busy, 0);
    end else begin
      sbad = 0;
      seed = 3'd7;
      for (int c = 0; c < 20; c++) begin
        start = (c == 5);
        if (resp_word !== ew || busy !== 1'b1 ||
            resp_valid !== 1'b1)
          sbad++;
        @(posedge clk);
        @(negedge clk);
      end
      start = 1'b0;
      check("hold_stable", sbad, 0);
      resp_ready = 1'b1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("hold_hs_valid", resp_valid, 0);
      check("hold_hs_busy", busy, 0);
      repeat (3) begin
        @(posedge clk);
        @(negedge clk);
      end
      check("start_ign_busy", busy, 0);
      check("start_ign_pulse", puf_pulse, 0);
    end
    resp_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    seed = 3'd5;
    puf_response = 1'b1;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pulse", puf_pulse, 0);
    check("rst_chal", puf_challenge, 0);
    check("rst_word", resp_word, 0);
    check("rst_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_pulse", puf_pulse, 0);

    run(3'd5, 0, 8'hFF, 1'b0);
    run(3'd0, 1, 8'hAA, 1'b0);
    run(3'd3, 1, 8'h55, 1'b1);

    @(negedge clk);
    seed = 3'd4;
    start = 1'b1;
    puf_response = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("pre_rst_pulse", puf_pulse, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pulse", puf_pulse, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_chal", puf_challenge, 0);
    check("mid_rst_word", resp_word, 0);
    check("mid_rst_valid", resp_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(3'd2, 0, 8'hFF, 1'b0);

`ifdef ARBITER_PUF_VOTE_EN
    run(3'd1, 2, 8'hFF, 1'b0);
    run(3'd6, 3, 8'h00, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
